// File: rtl/fc_pkg.sv
// Shared constants, state type and output post-processing for the dense layer.
package fc_pkg;

  localparam int unsigned QW     = 20;      // Q4.16 data/weight width
  localparam int unsigned QFRAC  = 16;
  localparam int unsigned PROD_W = 2 * QW;  // Q8.32 product
  localparam int unsigned ACC_W  = 52;      // Q20.32 accumulator
  localparam int unsigned AW_L   = 12;      // L1/L2 address width
  localparam int unsigned AW_W   = 14;      // weight ROM address width

  localparam logic [2:0] CSEL_OFF = 3'b000;
  localparam logic [2:0] CSEL_L1  = 3'b011;
  localparam logic [2:0] CSEL_L2  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_BIAS,
    ST_WRITE,
    ST_DONE
  } fc_state_e;

  // Adds the bias and a half-LSB, keeps bits [35:16], saturates high, then ReLU.
  function automatic logic [QW-1:0] fc_finish(input logic signed [ACC_W-1:0] acc,
                                              input logic signed [QW-1:0]    bias);
    logic [ACC_W-1:0]       sum;
    logic [ACC_W-QFRAC-1:0] r;
    logic [QW-1:0]          res;
    sum = acc + {{(ACC_W-QW-QFRAC){bias[QW-1]}}, bias, {QFRAC{1'b0}}}
              + (ACC_W'(1) << (QFRAC-1));
    r   = sum[ACC_W-1:QFRAC];
    if (r[ACC_W-QFRAC-1]) begin
      res = '0;
    end else if (r[ACC_W-QFRAC-2:QW-1] != '0) begin
      res = {1'b0, {(QW-1){1'b1}}};
    end else begin
      res = r[QW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_layer_if.sv
// Memory/control bundle between fc_layer (slave) and its L1/L2/weight environment (master).
interface fc_layer_if;
  import fc_pkg::*;

  logic             start;
  logic             busy;
  logic             crd;
  logic [AW_L-1:0]  caddr_rd;
  logic [QW-1:0]    cdata_rd;
  logic [2:0]       csel;
  logic [AW_W-1:0]  waddr;
  logic [QW-1:0]    wdata;
  logic             cwr;
  logic [AW_L-1:0]  caddr_wr;
  logic [QW-1:0]    cdata_wr;

  modport slave (
    input  start, cdata_rd, wdata,
    output busy, crd, caddr_rd, csel, waddr, cwr, caddr_wr, cdata_wr
  );

  modport master (
    output start, cdata_rd, wdata,
    input  busy, crd, caddr_rd, csel, waddr, cwr, caddr_wr, cdata_wr
  );
endinterface

// File: rtl/fc_mac.sv
// Register / multiply / accumulate pipeline; en marks the cycle an address pair is issued.
module fc_mac
  import fc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [QW-1:0]    a_in,
  input  logic signed [QW-1:0]    b_in,
  output logic signed [ACC_W-1:0] acc
);

  logic                    v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic signed [QW-1:0]    a_q, a_d, b_q, b_d;
  logic signed [PROD_W-1:0] p_q, p_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    v0_d  = en;
    v1_d  = v0_q;
    v2_d  = v1_q;
    a_d   = v0_q ? a_in : a_q;
    b_d   = v0_q ? b_in : b_q;
    p_d   = v1_q ? (PROD_W'(a_q) * PROD_W'(b_q)) : p_q;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (v2_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_layer.sv
// Fully connected layer: streams L1 against weight rows, adds bias, rounds/saturates/ReLUs into L2.
module fc_layer
  import fc_pkg::*;
#(
  parameter int unsigned N_IN  = 1024,
  parameter int unsigned N_OUT = 10
) (
  input logic       clk,
  input logic       reset,
  fc_layer_if.slave bus
);

  localparam logic [AW_L-1:0] LAST_I    = AW_L'(N_IN - 1);
  localparam logic [AW_L-1:0] LAST_O    = AW_L'(N_OUT - 1);
  localparam logic [AW_W-1:0] BIAS_BASE = AW_W'(N_OUT * N_IN);

  fc_state_e       state_q, state_d;
  logic [AW_L-1:0] cnt_q, cnt_d;
  logic [AW_L-1:0] o_q, o_d;
  logic [AW_W-1:0] wptr_q, wptr_d;
  logic            busy_q, busy_d;
  logic            crd_q, crd_d;
  logic [AW_L-1:0] caddr_rd_q, caddr_rd_d;
  logic [2:0]      csel_q, csel_d;
  logic [AW_W-1:0] waddr_q, waddr_d;
  logic            cwr_q, cwr_d;
  logic [AW_L-1:0] caddr_wr_q, caddr_wr_d;
  logic [QW-1:0]   cdata_wr_q, cdata_wr_d;

  logic                    mac_clr;
  logic                    issue;
  logic [AW_L-1:0]         issue_idx;
  logic [AW_W-1:0]         issue_ptr;
  logic signed [ACC_W-1:0] acc;

  fc_mac u_mac (
    .clk  (clk),
    .rst  (reset),
    .clr  (mac_clr),
    .en   (crd_q),
    .a_in (bus.cdata_rd),
    .b_in (bus.wdata),
    .acc  (acc)
  );

  // Weight rows are contiguous, so one running pointer walks all outputs without a multiply.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_d        = o_q;
    wptr_d     = wptr_q;
    busy_d     = busy_q;
    crd_d      = 1'b0;
    caddr_rd_d = '0;
    csel_d     = CSEL_OFF;
    waddr_d    = '0;
    cwr_d      = 1'b0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;
    mac_clr    = 1'b0;
    issue      = 1'b0;
    issue_idx  = '0;
    issue_ptr  = wptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_MAC;
          busy_d    = 1'b1;
          o_d       = '0;
          cnt_d     = '0;
          mac_clr   = 1'b1;
          issue     = 1'b1;
          issue_ptr = '0;
        end
      end
      ST_MAC: begin
        if (cnt_q == LAST_I) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + AW_L'(1);
          issue     = 1'b1;
          issue_idx = cnt_q + AW_L'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == AW_L'(1)) begin
          state_d = ST_BIAS;
          cnt_d   = '0;
          waddr_d = BIAS_BASE + {{(AW_W-AW_L){1'b0}}, o_q};
        end else begin
          cnt_d = AW_L'(1);
        end
      end
      ST_BIAS: begin
        if (cnt_q == '0) begin
          cnt_d   = AW_L'(1);
          waddr_d = waddr_q;
        end else begin
          state_d    = ST_WRITE;
          cnt_d      = '0;
          cwr_d      = 1'b1;
          csel_d     = CSEL_L2;
          caddr_wr_d = o_q;
          cdata_wr_d = fc_finish(acc, bus.wdata);
        end
      end
      ST_WRITE: begin
        if (o_q == LAST_O) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_MAC;
          o_d     = o_q + AW_L'(1);
          cnt_d   = '0;
          mac_clr = 1'b1;
          issue   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue) begin
      crd_d      = 1'b1;
      csel_d     = CSEL_L1;
      caddr_rd_d = issue_idx;
      waddr_d    = issue_ptr;
      wptr_d     = issue_ptr + AW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      o_q        <= '0;
      wptr_q     <= '0;
      busy_q     <= 1'b0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
      csel_q     <= CSEL_OFF;
      waddr_q    <= '0;
      cwr_q      <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_q        <= o_d;
      wptr_q     <= wptr_d;
      busy_q     <= busy_d;
      crd_q      <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      csel_q     <= csel_d;
      waddr_q    <= waddr_d;
      cwr_q      <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.crd      = crd_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.csel     = csel_q;
  assign bus.waddr    = waddr_q;
  assign bus.cwr      = cwr_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: uniform-pattern table, randomized run against an arithmetic model, start/reset corners.
module tb_fc_layer;
  import fc_pkg::*;

  localparam int unsigned N_IN    = 1024;
  localparam int unsigned N_OUT   = 10;
  localparam int unsigned NW      = N_OUT * N_IN + N_OUT;
  localparam int unsigned SPACING = N_IN + 5;
  localparam int unsigned BIAS0   = N_OUT * N_IN;

  logic clk = 1'b0;
  logic reset;

  fc_layer_if bus ();

  fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [19:0] l1_mem [N_IN];
  logic signed [19:0] w_mem  [NW];
  logic [19:0]        exp_out [N_OUT];

  always @(posedge clk) begin
    bus.cdata_rd <= l1_mem[int'(bus.caddr_rd) % N_IN];
    bus.wdata    <= w_mem[int'(bus.waddr) % NW];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.cwr === 1'b1) begin
      wr_addr.push_back(int'(bus.caddr_wr));
      wr_data.push_back(int'(bus.cdata_wr));
      wr_cyc.push_back(cyc);
      chk("crd_during_cwr", 32'(bus.crd), 32'd0);
      chk("csel_during_cwr", 32'(bus.csel), 32'h5);
    end
  end

  // Expected output straight from the arithmetic definition: exact sum, bias, round, clamp, ReLU.
  function automatic logic [19:0] model(input int o);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < int'(N_IN); i++)
      acc += longint'(l1_mem[i]) * longint'(w_mem[o * int'(N_IN) + i]);
    acc += longint'(w_mem[int'(BIAS0) + o]) * 65536 + 32768;
    r = acc >>> 16;
    if (r > 524287) return 20'h7FFFF;
    if (r < 0) return 20'h0;
    return r[19:0];
  endfunction

  function automatic logic [19:0] rnd(input int bits);
    int v;
    v = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    return v[19:0];
  endfunction

  task automatic fill_uniform(input logic [19:0] l1, input logic [19:0] w, input logic [19:0] b);
    for (int i = 0; i < int'(N_IN); i++) l1_mem[i] = l1;
    for (int i = 0; i < int'(BIAS0); i++) w_mem[i] = w;
    for (int o = 0; o < int'(N_OUT); o++) w_mem[int'(BIAS0) + o] = b;
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(N_IN); i++) l1_mem[i] = rnd(15);
    for (int o = 0; o < int'(N_OUT); o++) begin
      for (int i = 0; i < int'(N_IN); i++)
        w_mem[o * int'(N_IN) + i] = rnd((o % 3 == 0) ? 19 : 15);
      w_mem[int'(BIAS0) + o] = rnd(18);
    end
  endtask

  task automatic start_layer();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (bus.busy === 1'b1 && t < int'(N_OUT * SPACING + 50)) begin
      @(negedge clk);
      t++;
    end
    chk("run_finished", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wr_addr.size() < n && t < int'(N_OUT * SPACING + 50)) begin
      @(negedge clk);
      t++;
    end
    chk("writes_reached", 32'(wr_addr.size()), 32'(n));
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(N_OUT));
    for (int i = 0; i < wr_addr.size() && i < int'(N_OUT); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp_out[i]));
      if (i > 0)
        chk($sformatf("%s_spacing%0d", tag, i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(SPACING));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_crd"},      32'(bus.crd),      32'd0);
    chk({tag, "_cwr"},      32'(bus.cwr),      32'd0);
    chk({tag, "_csel"},     32'(bus.csel),     32'd0);
    chk({tag, "_caddr_rd"}, 32'(bus.caddr_rd), 32'd0);
    chk({tag, "_caddr_wr"}, 32'(bus.caddr_wr), 32'd0);
    chk({tag, "_cdata_wr"}, 32'(bus.cdata_wr), 32'd0);
    chk({tag, "_waddr"},    32'(bus.waddr),    32'd0);
  endtask

  typedef struct {
    logic [19:0] l1;
    logic [19:0] w;
    logic [19:0] b;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{20'h00000, 20'h12345, 20'h01310, 20'h01310, "zero_l1_bias"};
    vecs[1] = '{20'h00100, 20'h10000, 20'h00000, 20'h40000, "unit_weight"};
    vecs[2] = '{20'h7FFFF, 20'h7FFFF, 20'h00000, 20'h7FFFF, "saturate"};

    reset     = 1'b1;
    bus.start = 1'b0;
    fill_uniform(20'h0, 20'h0, 20'h0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      fill_uniform(vecs[v].l1, vecs[v].w, vecs[v].b);
      for (int o = 0; o < int'(N_OUT); o++) exp_out[o] = vecs[v].exp;
      start_layer();
      wait_done();
      check_writes(vecs[v].name);
    end

    // Random data; a start during output 3 and another during DONE must both be ignored.
    fill_random();
    for (int o = 0; o < int'(N_OUT); o++) exp_out[o] = model(o);
    start_layer();
    wait_writes(3);
    repeat (100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
    end
    check_writes("random");

    // Asynchronous reset in the middle of output 5 aborts the run.
    fill_random();
    start_layer();
    wait_writes(5);
    repeat (300) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("no_write_after_reset", 32'(wr_addr.size()), 32'd5);
    chk("idle_after_reset", 32'(bus.busy), 32'd0);

    // Re-run from o=0: outputs 0..8 negative (ReLU), output 9 a single half-LSB product (rounding).
    fill_uniform(20'h00100, 20'hF0000, 20'h0);
    l1_mem[0] = 20'h00001;
    for (int i = 0; i < int'(N_IN); i++) w_mem[9 * int'(N_IN) + i] = 20'h0;
    w_mem[9 * int'(N_IN)] = 20'h08000;
    for (int o = 0; o < int'(N_OUT); o++) exp_out[o] = model(o);
    start_layer();
    wait_done();
    check_writes("rerun");
    if (wr_data.size() == int'(N_OUT)) begin
      chk("relu_o0", 32'(wr_data[0]), 32'd0);
      chk("round_o9", 32'(wr_data[9]), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_layer.md
FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 Parameter N_IN, default 1024, SHALL set the number of L1 feature values per output (32x32 max-pool map).
REQ-002 Parameter N_OUT, default 10, SHALL set the number of dense outputs written to L2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse requesting a layer run; it is sampled only in IDLE.
REQ-006 busy  output  1  SHALL be high from the cycle after an accepted start until DONE.
REQ-007 crd  output  1  SHALL be the L1 read enable.
REQ-008 caddr_rd  output  12  SHALL be the L1 read address (0..N_IN-1).
REQ-009 cdata_rd  input  20  SHALL carry signed Q4.16 L1 data, valid one cycle after crd/caddr_rd.
REQ-010 csel  output  3  SHALL select memory: 3'b011 while reading L1, 3'b101 while writing L2, 3'b000 otherwise.
REQ-011 waddr  output  14  SHALL address the weight ROM: weight(o,i) at o*N_IN+i; bias(o) at N_OUT*N_IN+o.
REQ-012 wdata  input  20  SHALL carry signed Q4.16 weight/bias, valid one cycle after waddr.
REQ-013 cwr  output  1  SHALL be the L2 write strobe, one cycle per output.
REQ-014 caddr_wr  output  12  SHALL be the L2 write address, equal to output index o.
REQ-015 cdata_wr  output  20  SHALL be the Q4.16 write data.

Function
REQ-016 FSM states SHALL be IDLE, MAC, DRAIN, BIAS, WRITE, DONE.
REQ-017 IDLE->MAC on start; start while not in IDLE SHALL be ignored.
REQ-018 MAC: issue N_IN consecutive reads (crd=1, caddr_rd=i, waddr=o*N_IN+i), one per cycle, i=0..N_IN-1; then ->DRAIN.
REQ-019 Pipeline: address cycle k, data sampled cycle k+1, 40-bit product registered cycle k+2, accumulated cycle k+3.
REQ-020 DRAIN SHALL last exactly 2 cycles with crd=0, flushing the pipeline; then ->BIAS.
REQ-021 BIAS: issue waddr=N_OUT*N_IN+o, wait 1 cycle, capture bias; then ->WRITE.
REQ-022 Accumulator SHALL be 52-bit signed (Q20.32) and cleared on entry to MAC for each output.
REQ-023 Result = acc + (bias<<16) + (1<<15), then bits [35:16] (round half up).
REQ-024 Result SHALL saturate to 20'h7FFFF if acc exceeds the 20-bit signed range, then ReLU: negative results -> 0.
REQ-025 WRITE: cwr=1, csel=3'b101, caddr_wr=o, cdata_wr=result for exactly one cycle; o<N_OUT-1 -> o+1, ->MAC; else ->DONE.
REQ-026 Successive cwr pulses SHALL be spaced exactly N_IN+5 cycles (1029 at defaults).
REQ-027 DONE: busy=0 for one cycle, then ->IDLE; a start in DONE SHALL be ignored.
REQ-028 cwr and crd SHALL never be high in the same cycle.

Reset
REQ-029 On reset all outputs SHALL be 0 (busy, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr, waddr), FSM IDLE, o=0, accumulator 0.
REQ-030 Reset asserted mid-run SHALL abort immediately with no further cwr; next start restarts at o=0.

Structure
REQ-031 Package fc_pkg SHALL hold Q4.16 width constants, accumulator width, CSEL_L1=3'b011, CSEL_L2=3'b101, state enum type.
REQ-032 One sub-module fc_mac SHALL implement the register-multiply-accumulate pipeline with clear and enable inputs.

Verification
REQ-033 L1 all 0, biases 20'h01310 -> 10 writes, each cdata_wr=20'h01310, caddr_wr 0..9.
REQ-034 L1 all 20'h00100, weights 20'h10000, bias 0 -> every cdata_wr=20'h40000; cwr spacing 1029 cycles.
REQ-035 Weights 20'hF0000 (-1.0), L1 all 20'h00100 -> every cdata_wr=0 (ReLU).
REQ-036 L1 and weights all 20'h7FFFF -> every cdata_wr=20'h7FFFF (saturation); single product 20'h00001*20'h08000 elsewhere 0 -> cdata_wr=20'h00001 (rounding).
REQ-037 start pulsed during MAC of output 3 -> ignored, exactly 10 writes total; reset during output 5 -> outputs all 0 next cycle, no further cwr, re-run from o=0 correct.
